// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter.
// Holds the FSM state encoding and the master identifiers used for round-robin.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RECOVER = 2'd3
  } mem_arb_state_e;

  localparam logic MASTER_I = 1'b0;
  localparam logic MASTER_D = 1'b1;

endpackage

// File: rtl/mem_arb_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module mem_arb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache misses onto one memory port.
// Each grant is held until mem_ready, then a one-cycle RECOVER gap avoids double service.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   icache_mem_addr,
  input  logic                    icache_mem_req,
  output logic [DATA_WIDTH-1:0]   icache_mem_rdata,
  output logic                    icache_mem_ready,
  input  logic [ADDR_WIDTH-1:0]   dcache_mem_addr,
  input  logic [DATA_WIDTH-1:0]   dcache_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] dcache_mem_be,
  input  logic                    dcache_mem_we,
  input  logic                    dcache_mem_req,
  output logic [DATA_WIDTH-1:0]   dcache_mem_rdata,
  output logic                    dcache_mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_we,
  output logic                    mem_req,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic [CNT_WIDTH-1:0]    icache_txn_count,
  output logic [CNT_WIDTH-1:0]    dcache_txn_count,
  output logic                    timeout_error,
  output mem_arb_state_e          fsm_state
);

  // Handshake: a master holds req until its ready pulse; ready is a single-cycle
  // completion strobe and rdata is only meaningful in that cycle.

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_arb_state_e    state;
  mem_arb_state_e    next_state;
  logic              last_grant;
  logic              granted;
  logic [WAIT_W-1:0] wait_cnt;

  assign granted   = (state == GRANT_I) || (state == GRANT_D);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (icache_mem_req && dcache_mem_req) begin
          next_state = (last_grant == MASTER_D) ? GRANT_I : GRANT_D;
        end else if (icache_mem_req) begin
          next_state = GRANT_I;
        end else if (dcache_mem_req) begin
          next_state = GRANT_D;
        end
      end
      GRANT_I: if (mem_ready) next_state = RECOVER;
      GRANT_D: if (mem_ready) next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req          = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    mem_be           = '0;
    mem_we           = 1'b0;
    icache_mem_ready = 1'b0;
    dcache_mem_ready = 1'b0;
    icache_mem_rdata = '0;
    dcache_mem_rdata = '0;
    case (state)
      GRANT_I: begin
        mem_req          = 1'b1;
        mem_addr         = icache_mem_addr;
        mem_be           = '1;
        icache_mem_ready = mem_ready;
        icache_mem_rdata = mem_rdata;
        dcache_mem_rdata = mem_rdata;
      end
      GRANT_D: begin
        mem_req          = 1'b1;
        mem_addr         = dcache_mem_addr;
        mem_wdata        = dcache_mem_wdata;
        mem_be           = dcache_mem_be;
        mem_we           = dcache_mem_we;
        dcache_mem_ready = mem_ready;
        icache_mem_rdata = mem_rdata;
        dcache_mem_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  // Round-robin pointer and stall watchdog; the watchdog only flags, never aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= MASTER_D;
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      if (next_state == GRANT_I && state == IDLE) last_grant <= MASTER_I;
      if (next_state == GRANT_D && state == IDLE) last_grant <= MASTER_D;
      if (!granted) begin
        wait_cnt <= '0;
      end else if (!mem_ready) begin
        if (wait_cnt != WAIT_W'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) timeout_error <= 1'b1;
      end
    end
  end

  mem_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_icache_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (icache_mem_ready),
    .count (icache_txn_count)
  );

  mem_arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_dcache_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dcache_mem_ready),
    .count (dcache_txn_count)
  );

endmodule
